// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Works from pre-synchronized clock-fall strobes and drops a stalled frame after a timeout.
//
// state  | meaning
// IDLE   | waiting for a start bit (strobe with data low)
// DATA   | shifting in the 8 data bits, LSB first
// PARITY | waiting for the odd-parity bit
// STOP   | waiting for the stop bit; good frame or frame error decided here
module ps2_receiver #(
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_fall,
  input  logic       ps2_data,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timed_out;
  logic          parity_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      byte_q    <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      tmo_q     <= tmo_d;
    end
  end

  // Once the counter has reached its limit the frame is dead, even if a strobe arrives now.
  assign timed_out = (state_q != IDLE) && (tmo_q == TMO_MAX);
  assign parity_ok = ^{shift_q, par_q};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    tmo_d     = tmo_q;

    if (state_q == IDLE) begin
      tmo_d = '0;
    end else if (ps2_clk_fall) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + TW'(1);
    end

    if (timed_out) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      err_d     = 1'b1;
      tmo_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ps2_clk_fall && !ps2_data) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          if (ps2_clk_fall) begin
            shift_d   = {ps2_data, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = PARITY;
          end
        end
        PARITY: begin
          if (ps2_clk_fall) begin
            par_d   = ps2_data;
            state_d = STOP;
          end
        end
        STOP: begin
          if (ps2_clk_fall) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            if (ps2_data && parity_ok) begin
              byte_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign byte_data   = byte_q;
  assign byte_valid  = valid_q;
  assign frame_error = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver with a short timeout so stalled frames resolve quickly.
module tb_ps2_receiver;

  logic       clk;
  logic       reset;
  logic       ps2_clk_fall;
  logic       ps2_data;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_error;
  logic       busy;

  int total = 0;
  int bad   = 0;

  ps2_receiver #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk_fall(ps2_clk_fall),
    .ps2_data    (ps2_data),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One strobe; returns at the negedge right after the sampling edge, with data scrambled.
  task automatic strobe(input logic d);
    ps2_clk_fall = 1'b1;
    ps2_data     = d;
    @(negedge clk);
    ps2_clk_fall = 1'b0;
    ps2_data     = ~d;
  endtask

  // long_idx selects the data bit preceded by a 15-cycle gap (strobe lands as the counter would hit 16).
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int long_idx);
    strobe(1'b0);
    check("busy_after_start", {7'd0, busy}, 8'd1);
    for (int i = 0; i < 8; i++) begin
      idle((i == long_idx) ? 15 : 2);
      strobe(d[i]);
    end
    idle(2);
    strobe(par);
    idle(2);
    strobe(stp);
  endtask

  initial begin
    reset        = 1'b1;
    ps2_clk_fall = 1'b1;
    ps2_data     = 1'b0;
    idle(3);
    check("rst_byte_data", byte_data, 8'h00);
    check("rst_valid", {7'd0, byte_valid}, 8'd0);
    check("rst_err", {7'd0, frame_error}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    reset        = 1'b0;
    ps2_clk_fall = 1'b0;
    idle(2);
    check("rst_strobe_ignored_busy", {7'd0, busy}, 8'd0);

    // IDLE strobe with data high is not a start bit
    strobe(1'b1);
    check("idle_hi_busy", {7'd0, busy}, 8'd0);
    idle(1);
    check("idle_hi_valid", {7'd0, byte_valid}, 8'd0);
    check("idle_hi_err", {7'd0, frame_error}, 8'd0);

    // 0x1C, parity 0
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    check("f1c_valid", {7'd0, byte_valid}, 8'd1);
    check("f1c_data", byte_data, 8'h1C);
    check("f1c_busy", {7'd0, busy}, 8'd0);
    check("f1c_err", {7'd0, frame_error}, 8'd0);
    idle(1);
    check("f1c_valid_width", {7'd0, byte_valid}, 8'd0);

    // 0xF0, parity 1
    send_frame(8'hF0, 1'b1, 1'b1, -1);
    check("ff0_valid", {7'd0, byte_valid}, 8'd1);
    check("ff0_data", byte_data, 8'hF0);
    idle(1);

    // 0x1C with wrong parity
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    check("par_err", {7'd0, frame_error}, 8'd1);
    check("par_valid", {7'd0, byte_valid}, 8'd0);
    check("par_data_hold", byte_data, 8'hF0);
    check("par_busy", {7'd0, busy}, 8'd0);
    idle(1);
    check("par_err_width", {7'd0, frame_error}, 8'd0);

    // 0x55 with good parity but stop bit 0
    send_frame(8'h55, 1'b1, 1'b0, -1);
    check("stop_err", {7'd0, frame_error}, 8'd1);
    check("stop_valid", {7'd0, byte_valid}, 8'd0);
    check("stop_data_hold", byte_data, 8'hF0);
    idle(1);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    check("after_stop_valid", {7'd0, byte_valid}, 8'd1);
    check("after_stop_data", byte_data, 8'h1C);
    idle(1);

    // 0xA5 with a maximal gap before bit 4: the strobe wins over the timeout
    send_frame(8'hA5, 1'b1, 1'b1, 4);
    check("gap_valid", {7'd0, byte_valid}, 8'd1);
    check("gap_err", {7'd0, frame_error}, 8'd0);
    check("gap_data", byte_data, 8'hA5);
    idle(1);

    // Timeout: start + 3 data bits, then silence
    strobe(1'b0);
    idle(2); strobe(1'b1);
    idle(2); strobe(1'b0);
    idle(2); strobe(1'b1);
    idle(16);
    check("tmo_pre_err", {7'd0, frame_error}, 8'd0);
    check("tmo_pre_busy", {7'd0, busy}, 8'd1);
    idle(1);
    check("tmo_err", {7'd0, frame_error}, 8'd1);
    check("tmo_busy", {7'd0, busy}, 8'd0);
    check("tmo_valid", {7'd0, byte_valid}, 8'd0);
    check("tmo_data_hold", byte_data, 8'hA5);
    idle(1);
    check("tmo_err_width", {7'd0, frame_error}, 8'd0);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    check("after_tmo_valid", {7'd0, byte_valid}, 8'd1);
    check("after_tmo_data", byte_data, 8'h1C);
    idle(1);

    // Reset after 5 data bits discards the frame quietly
    strobe(1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(2);
      strobe(1'b1);
    end
    reset        = 1'b1;
    ps2_clk_fall = 1'b1;
    ps2_data     = 1'b0;
    @(negedge clk);
    check("midrst_busy", {7'd0, busy}, 8'd0);
    check("midrst_valid", {7'd0, byte_valid}, 8'd0);
    check("midrst_err", {7'd0, frame_error}, 8'd0);
    check("midrst_data", byte_data, 8'h00);
    reset        = 1'b0;
    ps2_clk_fall = 1'b0;
    idle(20);
    check("post_rst_err", {7'd0, frame_error}, 8'd0);
    check("post_rst_busy", {7'd0, busy}, 8'd0);
    send_frame(8'hF0, 1'b1, 1'b1, -1);
    check("post_rst_valid", {7'd0, byte_valid}, 8'd1);
    check("post_rst_data", byte_data, 8'hF0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
